// File: rtl/sdiv_seq.sv
// Iterative non-restoring signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Optional SDIV_ZERO_BYPASS_EN: a zero dividend with a nonzero divisor completes in one cycle.
module sdiv_seq #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dd,
    input  logic [W-1:0]     dv,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rema,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t          state_q;
    logic [W:0]      p_q;
    logic [W-1:0]    lo_q;
    logic [W-1:0]    dv_abs_q;
    logic [W-1:0]    qmag_q;
    logic [CW-1:0]   cnt_q;
    logic            qneg_q, rneg_q;
    logic            busy_q, done_q, dbz_q, ovf_q;
    logic [W-1:0]    quot_q, rema_q;

    logic [2*W-1:0]  dd_abs;
    logic [W-1:0]    dv_abs;
    logic [W:0]      p_sh, p_d, p_fix;
    logic [W-1:0]    qmag_d, q_signed, r_signed;
    logic            q_ovf;

    // Magnitudes in unsigned form; the most negative dividend maps to 2^(2W-1).
    assign dd_abs = dd[2*W-1] ? (~dd + (2*W)'(1)) : dd;
    assign dv_abs = dv[W-1]   ? (~dv + W'(1))     : dv;

    // Decision uses the sign of the shifted partial remainder.
    assign p_sh   = {p_q[W-1:0], lo_q[W-1]};
    assign p_d    = p_sh[W] ? (p_sh + {1'b0, dv_abs_q}) : (p_sh - {1'b0, dv_abs_q});
    assign qmag_d = {qmag_q[W-2:0], ~p_d[W]};

    assign p_fix    = p_q[W] ? (p_q + {1'b0, dv_abs_q}) : p_q;
    assign q_signed = qneg_q ? (~qmag_q + W'(1)) : qmag_q;
    assign r_signed = rneg_q ? (~p_fix[W-1:0] + W'(1)) : p_fix[W-1:0];
    assign q_ovf    = qneg_q ? (qmag_q > QMIN) : qmag_q[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            p_q      <= '0;
            lo_q     <= '0;
            dv_abs_q <= '0;
            qmag_q   <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            quot_q   <= '0;
            rema_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        p_q      <= {1'b0, dd_abs[2*W-1:W]};
                        lo_q     <= dd_abs[W-1:0];
                        dv_abs_q <= dv_abs;
                        qneg_q   <= dd[2*W-1] ^ dv[W-1];
                        rneg_q   <= dd[2*W-1];
                        qmag_q   <= '0;
                        cnt_q    <= '0;
                        dbz_q    <= 1'b0;
                        ovf_q    <= 1'b0;
                        if (dv == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rema_q  <= dd[W-1:0];
                            dbz_q   <= 1'b1;
                        end else if (dd_abs[2*W-1:W] >= dv_abs) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= QMIN;
                            rema_q  <= '0;
                            ovf_q   <= 1'b1;
`ifdef SDIV_ZERO_BYPASS_EN
                        end else if (dd == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '0;
                            rema_q  <= '0;
`endif
                        end else begin
                            state_q <= ITER;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    p_q    <= p_d;
                    lo_q   <= lo_q << 1;
                    qmag_q <= qmag_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W-1))
                        state_q <= FIX;
                end
                FIX: begin
                    p_q     <= p_fix;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                    if (q_ovf) begin
                        quot_q <= QMIN;
                        rema_q <= '0;
                        ovf_q  <= 1'b1;
                    end else begin
                        quot_q <= q_signed;
                        rema_q <= r_signed;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rema        = rema_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule

// File: tb/tb_sdiv_seq.sv
// Random and directed bench for sdiv_seq (W=32) against a plain-arithmetic reference model.
module tb_sdiv_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   dd = '0;
    logic [31:0]   dv = '0;
    logic          busy, done, div_by_zero, overflow;
    logic [31:0]   quot, rema;

    int total = 0;
    int bad = 0;

    sdiv_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dd(dd), .dv(dv),
        .busy(busy), .done(done), .quot(quot), .rema(rema),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: integer division of magnitudes, then sign and range rules.
    task automatic model(input logic [63:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output logic o, output int lat);
        logic [63:0] aa, qm, rm;
        logic [31:0] bm;
        logic qn;
        z = 1'b0; o = 1'b0; lat = W + 2;
        aa = a[63] ? -a : a;
        bm = b[31] ? -b : b;
        if (b == 32'd0) begin
            q = '1; r = a[31:0]; z = 1'b1; lat = 1;
        end else begin
            qm = aa / {32'd0, bm};
            rm = aa % {32'd0, bm};
            qn = a[63] ^ b[31];
            if (aa[63:32] >= bm) lat = 1;
`ifdef SDIV_ZERO_BYPASS_EN
            if (a == 64'd0) lat = 1;
`endif
            if (qm > (qn ? 64'h8000_0000 : 64'h7fff_ffff)) begin
                o = 1'b1; q = 32'h8000_0000; r = '0;
            end else begin
                q = qn ? -qm[31:0] : qm[31:0];
                r = a[63] ? -rm[31:0] : rm[31:0];
            end
        end
    endtask

    task automatic run(input logic [63:0] a, input logic [31:0] b, input bit spam);
        logic [31:0] eq, er;
        logic ez, eo;
        int el, lat;
        bit bsy_ok;
        model(a, b, eq, er, ez, eo, el);
        @(negedge clk);
        dd = a; dv = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; bsy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (busy !== 1'b1) bsy_ok = 1'b0;
            if (spam) begin
                start = 1'b1; dd = {$urandom, $urandom}; dv = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("latency", 64'(lat), 64'(el));
        chk("quot", {32'd0, quot}, {32'd0, eq});
        chk("rema", {32'd0, rema}, {32'd0, er});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ez});
        chk("overflow", {63'd0, overflow}, {63'd0, eo});
        chk("busy_during", {63'd0, bsy_ok}, 64'd1);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [31:0] rb;
        longint x, y;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_quot", {32'd0, quot}, 64'd0);
        chk("rst_rema", {32'd0, rema}, 64'd0);
        chk("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(64'd100, 32'd7, 1'b0);
        run(-64'd100, 32'd7, 1'b0);
        run(64'd100, -32'd7, 1'b0);
        run(-64'd100, -32'd7, 1'b0);
        run(64'd5, 32'd0, 1'b0);
        run(64'h1_0000_0000, 32'd1, 1'b0);
        run(-64'h8000_0000, 32'd1, 1'b0);
        run(64'h8000_0000, 32'd1, 1'b0);
        run(64'h8000_0000_0000_0000, 32'hffff_ffff, 1'b0);
        run(64'd0, 32'd9, 1'b0);
        run(64'd123456789, 32'd1000, 1'b1);

        // Reset at iteration 10 aborts without a done pulse.
        @(negedge clk);
        dd = 64'd100; dv = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_quot", {32'd0, quot}, 64'd0);
        chk("abort_rema", {32'd0, rema}, 64'd0);
        chk("abort_flags", {62'd0, div_by_zero, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        run(64'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    ra = 64'(longint'(int'($urandom)));
                    rb = 32'(int'($urandom) >>> 16);
                end
                1: begin
                    ra = {$urandom, $urandom};
                    rb = $urandom;
                end
                default: begin
                    x = longint'(int'($urandom));
                    y = longint'(int'($urandom) >>> 1);
                    ra = 64'(x * y + longint'($urandom_range(0, 100)));
                    rb = 32'(x);
                end
            endcase
            run(ra, rb, i[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
